// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter: default widths, grant
// source encoding and the default-width broadcast record.
package wb_arbiter_pkg;

  localparam int unsigned SB_SIZE_WIDTH = 4;
  localparam int unsigned REG_WIDTH     = 5;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned ADDR_WIDTH    = 32;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LS   = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [SB_SIZE_WIDTH-1:0] pos;
    logic [REG_WIDTH-1:0]     rd;
    logic [DATA_WIDTH-1:0]    value;
    logic [ADDR_WIDTH-1:0]    offset;
  } wb_rec_t;

endpackage

// File: rtl/wb_alu_fifo.sv
// Small synchronous FIFO with head peek and occupancy count; holds ALU
// results waiting for a write-back slot.
module wb_alu_fifo #(
  parameter int unsigned WIDTH = 73,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back bus arbiter: merges the stall-free ALU (buffered in a small
// queue) with the handshaking load/store unit, one registered broadcast
// per cycle, with a starvation guard for LS and ALU issue hold.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned SB_SIZE_WIDTH = wb_arbiter_pkg::SB_SIZE_WIDTH,
  parameter int unsigned REG_WIDTH     = wb_arbiter_pkg::REG_WIDTH,
  parameter int unsigned DATA_WIDTH    = wb_arbiter_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = wb_arbiter_pkg::ADDR_WIDTH,
  parameter int unsigned ALU_Q_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [SB_SIZE_WIDTH-1:0] alu_pos,
  input  logic [REG_WIDTH-1:0]     alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_value,
  input  logic [ADDR_WIDTH-1:0]    alu_offset,
  output logic                     alu_hold,
  input  logic                     ls_valid,
  output logic                     ls_ready,
  input  logic [SB_SIZE_WIDTH-1:0] ls_pos,
  input  logic [REG_WIDTH-1:0]     ls_rd,
  input  logic [DATA_WIDTH-1:0]    ls_value,
  output logic                     wb_valid,
  output logic [SB_SIZE_WIDTH-1:0] wb_pos,
  output logic [REG_WIDTH-1:0]     wb_rd,
  output logic [DATA_WIDTH-1:0]    wb_value,
  output logic [ADDR_WIDTH-1:0]    wb_offset,
  output logic                     ovf_err
);

  localparam int unsigned REC_W = SB_SIZE_WIDTH + REG_WIDTH + DATA_WIDTH + ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(ALU_Q_DEPTH) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [REC_W-1:0] alu_rec;
  logic [REC_W-1:0] ls_rec;
  logic [REC_W-1:0] q_head;
  logic [REC_W-1:0] cand_rec;
  logic [REC_W-1:0] grant_rec;
  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             q_empty;
  logic [STV_W-1:0] starve_cnt;
  wb_src_e          grant_src;
  logic             alu_cand;
  logic             force_ls;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             ovf_now;

  assign alu_rec  = {alu_pos, alu_rd, alu_value, alu_offset};
  assign ls_rec   = {ls_pos, ls_rd, ls_value, {ADDR_WIDTH{1'b0}}};
  assign alu_cand = !q_empty || alu_valid;
  assign cand_rec = q_empty ? alu_rec : q_head;
  assign force_ls = ls_valid && (starve_cnt == STV_W'(STARVE_LIMIT));

  // Single-winner grant: starved LS first, then ALU, then LS.
  always_comb begin
    grant_src = SRC_NONE;
    grant_rec = '0;
    if (force_ls) begin
      grant_src = SRC_LS;
      grant_rec = ls_rec;
    end else if (alu_cand) begin
      grant_src = SRC_ALU;
      grant_rec = cand_rec;
    end else if (ls_valid) begin
      grant_src = SRC_LS;
      grant_rec = ls_rec;
    end
  end

  assign ls_ready = (grant_src == SRC_LS);
  assign bypass   = (grant_src == SRC_ALU) && q_empty;
  assign pop      = (grant_src == SRC_ALU) && !q_empty;
  assign push     = alu_valid && !bypass;
  assign ovf_now  = push && q_full && !pop;
  // One issued op may still be in flight, so hold one slot early.
  assign alu_hold = (q_count >= CNT_W'(ALU_Q_DEPTH - 1));

  wb_alu_fifo #(
    .WIDTH (REC_W),
    .DEPTH (ALU_Q_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push && !ovf_now),
    .pop   (pop),
    .din   (alu_rec),
    .head  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  // Count consecutive cycles a pending LS result is denied, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!ls_valid || (grant_src == SRC_LS)) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STV_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Register the granted record onto the broadcast bus; fields hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid  <= 1'b0;
      wb_pos    <= '0;
      wb_rd     <= '0;
      wb_value  <= '0;
      wb_offset <= '0;
    end else begin
      wb_valid <= (grant_src != SRC_NONE);
      if (grant_src != SRC_NONE) begin
        {wb_pos, wb_rd, wb_value, wb_offset} <= grant_rec;
      end
    end
  end

  // Sticky overflow flag: a dropped ALU result is only cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_err <= 1'b0;
    end else if (ovf_now) begin
      ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter with default parameters.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  alu_pos;
  logic [4:0]  alu_rd;
  logic [31:0] alu_value;
  logic [31:0] alu_offset;
  logic        alu_hold;
  logic        ls_valid;
  logic        ls_ready;
  logic [3:0]  ls_pos;
  logic [4:0]  ls_rd;
  logic [31:0] ls_value;
  logic        wb_valid;
  logic [3:0]  wb_pos;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;
  logic [31:0] wb_offset;
  logic        ovf_err;

  int tests;
  int fails;

  wb_arbiter #(
    .ALU_Q_DEPTH  (2),
    .STARVE_LIMIT (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_pos    (alu_pos),
    .alu_rd     (alu_rd),
    .alu_value  (alu_value),
    .alu_offset (alu_offset),
    .alu_hold   (alu_hold),
    .ls_valid   (ls_valid),
    .ls_ready   (ls_ready),
    .ls_pos     (ls_pos),
    .ls_rd      (ls_rd),
    .ls_value   (ls_value),
    .wb_valid   (wb_valid),
    .wb_pos     (wb_pos),
    .wb_rd      (wb_rd),
    .wb_value   (wb_value),
    .wb_offset  (wb_offset),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic av, input logic [3:0] ap, input logic [4:0] ard,
                        input logic [31:0] aval, input logic [31:0] aoff,
                        input logic lv, input logic [3:0] lp, input logic [4:0] lrd,
                        input logic [31:0] lval);
    alu_valid  = av;
    alu_pos    = ap;
    alu_rd     = ard;
    alu_value  = aval;
    alu_offset = aoff;
    ls_valid   = lv;
    ls_pos     = lp;
    ls_rd      = lrd;
    ls_value   = lval;
  endtask

  task automatic set_idle();
    set_in(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b0, 4'd0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(1'b1, 4'd7, 5'd7, 32'h77, 32'h70, 1'b0, 4'd0, 5'd0, 32'd0);
    tick();
    tick();
    tests++;
    if (wb_valid !== 1'b0 || wb_pos !== 4'd0 || wb_rd !== 5'd0) begin
      fails++;
      $display("FAIL reset_wb_ctl: valid=%b pos=%0d rd=%0d, want 0 0 0", wb_valid, wb_pos, wb_rd);
    end
    tests++;
    if (wb_value !== 32'd0 || wb_offset !== 32'd0 || ovf_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_wb_data: value=%h offset=%h ovf=%b, want 0 0 0", wb_value, wb_offset, ovf_err);
    end
    tests++;
    if (alu_hold !== 1'b0 || ls_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_comb: hold=%b ls_ready=%b, want 0 0", alu_hold, ls_ready);
    end
    set_idle();
    rst = 1'b1;
    tick();
    tests++;
    if (wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: wb_valid=%b, want 0", wb_valid);
    end
  endtask

  task automatic test_bypass();
    set_in(1'b1, 4'd3, 5'd5, 32'h11, 32'd0, 1'b0, 4'd0, 5'd0, 32'd0);
    #1;
    tests++;
    if (ls_ready !== 1'b0 || alu_hold !== 1'b0) begin
      fails++;
      $display("FAIL bypass_comb: ls_ready=%b hold=%b, want 0 0", ls_ready, alu_hold);
    end
    tick();
    tests++;
    if (wb_valid !== 1'b1 || wb_pos !== 4'd3 || wb_rd !== 5'd5 || wb_value !== 32'h11 || wb_offset !== 32'd0) begin
      fails++;
      $display("FAIL bypass_wb: v=%b pos=%0d rd=%0d val=%h off=%h, want 1 3 5 11 0",
               wb_valid, wb_pos, wb_rd, wb_value, wb_offset);
    end
    tests++;
    if (dut.q_count !== 2'd0) begin
      fails++;
      $display("FAIL bypass_queue: count=%0d, want 0", dut.q_count);
    end
    set_idle();
    tick();
    tests++;
    if (wb_valid !== 1'b0 || wb_pos !== 4'd3 || wb_value !== 32'h11) begin
      fails++;
      $display("FAIL idle_hold: v=%b pos=%0d val=%h, want 0 3 11", wb_valid, wb_pos, wb_value);
    end
  endtask

  task automatic test_collision();
    set_in(1'b1, 4'd1, 5'd2, 32'h22, 32'h40, 1'b1, 4'd2, 5'd7, 32'hAB);
    #1;
    tests++;
    if (ls_ready !== 1'b0) begin
      fails++;
      $display("FAIL coll_c0_ready: ls_ready=%b, want 0", ls_ready);
    end
    tick();
    tests++;
    if (wb_valid !== 1'b1 || wb_pos !== 4'd1 || wb_value !== 32'h22 || wb_offset !== 32'h40) begin
      fails++;
      $display("FAIL coll_alu_wb: v=%b pos=%0d val=%h off=%h, want 1 1 22 40", wb_valid, wb_pos, wb_value, wb_offset);
    end
    set_in(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b1, 4'd2, 5'd7, 32'hAB);
    #1;
    tests++;
    if (ls_ready !== 1'b1) begin
      fails++;
      $display("FAIL coll_c1_ready: ls_ready=%b, want 1", ls_ready);
    end
    tick();
    tests++;
    if (wb_valid !== 1'b1 || wb_pos !== 4'd2 || wb_rd !== 5'd7 || wb_value !== 32'hAB || wb_offset !== 32'd0) begin
      fails++;
      $display("FAIL coll_ls_wb: v=%b pos=%0d rd=%0d val=%h off=%h, want 1 2 7 ab 0",
               wb_valid, wb_pos, wb_rd, wb_value, wb_offset);
    end
    set_idle();
    tick();
  endtask

  // ALU streams pos 8..11 while LS (pos 12) waits; LS forced on the 4th cycle.
  task automatic run_starve_setup(input bit check);
    logic [3:0] exp_wb [4];
    logic       exp_rdy [4];
    exp_wb  = '{4'd8, 4'd9, 4'd10, 4'd12};
    exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int unsigned c = 0; c < 4; c++) begin
      set_in(1'b1, 4'(8 + c), 5'd1, 32'h200 + c, 32'd0, 1'b1, 4'd12, 5'd9, 32'h5A);
      #1;
      if (check) begin
        tests++;
        if (ls_ready !== exp_rdy[c] || alu_hold !== 1'b0) begin
          fails++;
          $display("FAIL starve_c%0d_comb: ls_ready=%b hold=%b, want %b 0", c, ls_ready, alu_hold, exp_rdy[c]);
        end
      end
      tick();
      if (check) begin
        tests++;
        if (wb_valid !== 1'b1 || wb_pos !== exp_wb[c]) begin
          fails++;
          $display("FAIL starve_c%0d_wb: v=%b pos=%0d, want 1 %0d", c, wb_valid, wb_pos, exp_wb[c]);
        end
      end
    end
  endtask

  task automatic test_starve();
    run_starve_setup(1'b1);
    tests++;
    if (dut.q_count !== 2'd1 || alu_hold !== 1'b1 || ovf_err !== 1'b0) begin
      fails++;
      $display("FAIL starve_queue: count=%0d hold=%b ovf=%b, want 1 1 0", dut.q_count, alu_hold, ovf_err);
    end
    set_idle();
    tick();
    tests++;
    if (wb_valid !== 1'b1 || wb_pos !== 4'd11 || wb_value !== 32'h203 || alu_hold !== 1'b0) begin
      fails++;
      $display("FAIL starve_drain: v=%b pos=%0d val=%h hold=%b, want 1 11 203 0", wb_valid, wb_pos, wb_value, alu_hold);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [3:0] exp_pos [14];
    exp_pos = '{4'd0, 4'd1, 4'd2, 4'd15, 4'd3, 4'd4, 4'd5, 4'd15, 4'd6, 4'd7, 4'd8, 4'd15, 4'd9, 4'd10};
    for (int unsigned c = 0; c < 14; c++) begin
      if (c < 12) set_in(1'b1, 4'(c), 5'd4, 32'h100 + c, 32'd0, 1'b1, 4'd15, 5'd3, 32'hCC);
      else        set_idle();
      #1;
      tests++;
      if (ls_ready !== ((c % 4 == 3) && c < 12)) begin
        fails++;
        $display("FAIL ovf_c%0d_ready: ls_ready=%b, want %b", c, ls_ready, ((c % 4 == 3) && c < 12));
      end
      tick();
      tests++;
      if (wb_valid !== 1'b1 || wb_pos !== exp_pos[c]) begin
        fails++;
        $display("FAIL ovf_c%0d_wb: v=%b pos=%0d, want 1 %0d", c, wb_valid, wb_pos, exp_pos[c]);
      end
      tests++;
      if (ovf_err !== (c >= 11)) begin
        fails++;
        $display("FAIL ovf_c%0d_flag: ovf=%b, want %b", c, ovf_err, (c >= 11));
      end
      if (c == 11) begin
        tests++;
        if (dut.q_count !== 2'd2) begin
          fails++;
          $display("FAIL ovf_full_count: count=%0d, want 2", dut.q_count);
        end
      end
    end
    tick();
    tests++;
    if (wb_valid !== 1'b0 || dut.q_count !== 2'd0) begin
      fails++;
      $display("FAIL ovf_drained: v=%b count=%0d, want 0 0", wb_valid, dut.q_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int unsigned c = 0; c < 4; c++) begin
      if (c < 3) set_in(1'b1, 4'(4 + c), 5'(10 + c), 32'h300 + c, 32'h1000 + c, 1'b0, 4'd0, 5'd0, 32'd0);
      else       set_idle();
      #1;
      tests++;
      if (alu_hold !== 1'b0) begin
        fails++;
        $display("FAIL b2b_c%0d_hold: hold=%b, want 0", c, alu_hold);
      end
      tick();
      tests++;
      if (c < 3) begin
        if (wb_valid !== 1'b1 || wb_pos !== 4'(4 + c) || wb_rd !== 5'(10 + c) || wb_offset !== 32'h1000 + c) begin
          fails++;
          $display("FAIL b2b_c%0d_wb: v=%b pos=%0d rd=%0d off=%h, want 1 %0d %0d %h",
                   c, wb_valid, wb_pos, wb_rd, wb_offset, 4 + c, 10 + c, 32'h1000 + c);
        end
      end else if (wb_valid !== 1'b0 || ovf_err !== 1'b1) begin
        fails++;
        $display("FAIL b2b_end: v=%b ovf=%b, want 0 1", wb_valid, ovf_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    run_starve_setup(1'b0);
    tests++;
    if (wb_valid !== 1'b1 || dut.q_count !== 2'd1 || ovf_err !== 1'b1) begin
      fails++;
      $display("FAIL rmid_pre: v=%b count=%0d ovf=%b, want 1 1 1", wb_valid, dut.q_count, ovf_err);
    end
    #2;
    rst = 1'b0;
    set_idle();
    #1;
    tests++;
    if (wb_valid !== 1'b0 || wb_pos !== 4'd0 || dut.q_count !== 2'd0 || ovf_err !== 1'b0 || alu_hold !== 1'b0) begin
      fails++;
      $display("FAIL rmid_async: v=%b pos=%0d count=%0d ovf=%b hold=%b, want 0 0 0 0 0",
               wb_valid, wb_pos, dut.q_count, ovf_err, alu_hold);
    end
    tick();
    tick();
    rst = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (wb_valid !== 1'b0) begin
        fails++;
        $display("FAIL rmid_stale_c%0d: wb_valid=%b pos=%0d, want 0", c, wb_valid, wb_pos);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    set_idle();
    rst = 1'b0;
    #1;
    test_reset();
    test_bypass();
    test_collision();
    test_starve();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
